// File: rtl/fetch_prefetch_buffer_pkg.sv
// Shared fetch-stage types: queue entry, decode-facing bundle, NOP encoding.
package fetch_prefetch_buffer_pkg;

    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } fetch_entry_type;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instruction;
    } fetch_decode_type;

endpackage

// File: rtl/fetch_prefetch_buffer_if.sv
// Fetch front-end bus: program-memory port, redirect input, decode handshake.
interface fetch_prefetch_buffer_if #(
    parameter int PC_WIDTH        = 32,
    parameter int IMEM_ADDR_WIDTH = 5
);
    logic [IMEM_ADDR_WIDTH-1:0] imem_address;
    logic [31:0]                imem_read_data;
    logic                       redirect_valid;
    logic [PC_WIDTH-1:0]        redirect_pc;
    logic                       out_valid;
    logic                       out_ready;
    logic [PC_WIDTH-1:0]        out_pc;
    logic [31:0]                out_instruction;

    modport master (
        output imem_address,
        input  imem_read_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instruction
    );

    modport slave (
        input  imem_address,
        output imem_read_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instruction
    );
endinterface

// File: rtl/fetch_prefetch_buffer_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush; head is registered storage.
module fetch_fifo
    import fetch_prefetch_buffer_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush_i,
    input  logic            push_i,
    input  fetch_entry_type push_data_i,
    input  logic            pop_i,
    output fetch_entry_type head_o,
    output logic [CW-1:0]   count_o
);
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;
    fetch_entry_type mem_q [DEPTH];

    always_comb begin
        do_push  = push_i && !flush_i;
        do_pop   = pop_i && !flush_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Fetch front end: owns the PC, drives program memory, queues returned words for decode.
module fetch_prefetch_buffer
    import fetch_prefetch_buffer_pkg::*;
#(
    parameter int                PC_WIDTH        = 32,
    parameter int                IMEM_ADDR_WIDTH = 5,
    parameter int                DEPTH           = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC      = '0
) (
    input logic                   clk,
    input logic                   reset_n,
    fetch_prefetch_buffer_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic                inflight_q, inflight_d;
    logic [CW:0]         occupancy;
    logic                issue;
    logic                redirect;
    logic                out_valid;
    logic                push, pop;
    logic [CW-1:0]       count;
    fetch_entry_type     head;
    fetch_entry_type     push_entry;

    assign redirect = bus.redirect_valid;

    // Credit counts the outstanding read; a same-cycle pop earns nothing.
    always_comb begin
        occupancy = {1'b0, count} + (CW + 1)'(inflight_q);
        issue     = occupancy < (CW + 1)'(DEPTH);
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        if (redirect) begin
            inflight_d    = 1'b1;
            inflight_pc_d = bus.redirect_pc;
            fetch_pc_d    = bus.redirect_pc + PC_WIDTH'(4);
        end else if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + PC_WIDTH'(4);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            inflight_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    assign bus.imem_address = redirect ? bus.redirect_pc[IMEM_ADDR_WIDTH-1:0]
                                       : fetch_pc_q[IMEM_ADDR_WIDTH-1:0];

    assign push       = inflight_q && !redirect;
    assign pop        = out_valid && bus.out_ready && !redirect;
    assign push_entry = '{pc: 32'(inflight_pc_q), instruction: bus.imem_read_data};

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (redirect),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    assign out_valid           = (count != '0);
    assign bus.out_valid       = out_valid;
    assign bus.out_pc          = out_valid ? PC_WIDTH'(head.pc) : '0;
    assign bus.out_instruction = out_valid ? head.instruction : NOP_INSTRUCTION;

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for fetch_prefetch_buffer: cycle table plus scoreboard of expected PCs.
module tb_fetch_prefetch_buffer;
    import fetch_prefetch_buffer_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad = 0;
    int   tcyc = 0;
    int   last_pop = -1;
    logic sb_en = 1'b0;
    logic gap_chk = 1'b0;
    logic [31:0] sb_q [$];
    logic [31:0] sb_exp;

    typedef struct {
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [4:0]  exp_addr;
    } vec_t;
    vec_t tv [8];

    fetch_prefetch_buffer_if #(.PC_WIDTH(32), .IMEM_ADDR_WIDTH(5)) bus ();

    fetch_prefetch_buffer #(
        .PC_WIDTH(32), .IMEM_ADDR_WIDTH(5), .DEPTH(4), .RESET_PC(32'h0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tcyc <= tcyc + 1;

    // Memory model: word = address | 0xA500_0000, one cycle latency.
    always @(posedge clk)
        bus.imem_read_data <= 32'hA500_0000 | {27'd0, bus.imem_address};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] word_of(logic [31:0] pc);
        return 32'hA500_0000 | {27'd0, pc[4:0]};
    endfunction

    always @(negedge clk) begin
        if (reset_n && sb_en && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got pc %h want none", bus.out_pc);
            end else begin
                sb_exp = sb_q.pop_front();
                chk("sb_pc", bus.out_pc, sb_exp);
                chk("sb_instr", bus.out_instruction, word_of(sb_exp));
            end
            if (gap_chk && last_pop >= 0)
                chk("gap_le2", 32'(tcyc - last_pop <= 2), 32'd1);
            last_pop = tcyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic rdy);
        reset_n = 1'b0;
        bus.out_ready = rdy;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        chk("drain_left", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic push_run(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(start + 32'(4 * i));
    endtask

    initial begin
        tv[0] = '{1'b1, 1'b0, 32'h00, NOP_INSTRUCTION, 5'h00};
        tv[1] = '{1'b1, 1'b0, 32'h00, NOP_INSTRUCTION, 5'h04};
        tv[2] = '{1'b1, 1'b1, 32'h00, 32'hA500_0000, 5'h08};
        tv[3] = '{1'b1, 1'b1, 32'h04, 32'hA500_0004, 5'h0C};
        tv[4] = '{1'b1, 1'b1, 32'h08, 32'hA500_0008, 5'h10};
        tv[5] = '{1'b1, 1'b1, 32'h0C, 32'hA500_000C, 5'h14};
        tv[6] = '{1'b0, 1'b1, 32'h10, 32'hA500_0010, 5'h18};
        tv[7] = '{1'b0, 1'b1, 32'h10, 32'hA500_0010, 5'h1C};

        reset_n = 1'b0;
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_pc", bus.out_pc, 32'd0);
        chk("rst_instr", bus.out_instruction, NOP_INSTRUCTION);
        chk("rst_addr", 32'(bus.imem_address), 32'd0);

        // Stream from reset, then stall decode
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.out_ready = tv[i].rdy;
            @(negedge clk);
            chk("tv_valid", 32'(bus.out_valid), 32'(tv[i].exp_valid));
            chk("tv_pc", bus.out_pc, tv[i].exp_pc);
            chk("tv_instr", bus.out_instruction, tv[i].exp_instr);
            chk("tv_addr", 32'(bus.imem_address), 32'(tv[i].exp_addr));
            step();
        end

        // Stalled from reset: fill, hold, then release
        start_run(1'b0);
        sb_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i >= 6) begin
                chk("full_addr", 32'(bus.imem_address), 32'h10);
                chk("full_count", 32'(dut.u_fifo.count_o), 32'd4);
                chk("full_valid", 32'(bus.out_valid), 32'd1);
                chk("full_pc", bus.out_pc, 32'h0);
                chk("full_instr", bus.out_instruction, 32'hA500_0000);
            end
            step();
        end
        push_run(32'h0, 6);
        gap_chk = 1'b1;
        last_pop = -1;
        bus.out_ready = 1'b1;
        drain(20);
        gap_chk = 1'b0;

        // Redirect mid-stream to 0x08 in cycle 6
        start_run(1'b1);
        push_run(32'h0, 4);
        push_run(32'h8, 3);
        for (int i = 0; i < 9; i++) begin
            bus.redirect_valid = (i == 6);
            bus.redirect_pc = 32'h8;
            @(negedge clk);
            if (i == 6) chk("rd1_oldpc", bus.out_pc, 32'h10);
            if (i == 7) chk("rd1_gap", 32'(bus.out_valid), 32'd0);
            if (i == 8) chk("rd1_pc", bus.out_pc, 32'h8);
            step();
        end
        bus.redirect_valid = 1'b0;
        drain(10);

        // Full queue, stalled, redirect to 0x14
        start_run(1'b0);
        for (int i = 0; i < 9; i++) begin
            bus.redirect_valid = (i == 6);
            bus.redirect_pc = 32'h14;
            @(negedge clk);
            if (i == 5) chk("rd2_count_full", 32'(dut.u_fifo.count_o), 32'd4);
            if (i == 7) begin
                chk("rd2_valid", 32'(bus.out_valid), 32'd0);
                chk("rd2_count", 32'(dut.u_fifo.count_o), 32'd0);
            end
            if (i == 8) begin
                chk("rd2_pc", bus.out_pc, 32'h14);
                chk("rd2_instr", bus.out_instruction, 32'hA500_0014);
            end
            step();
        end
        bus.redirect_valid = 1'b0;
        push_run(32'h14, 4);
        bus.out_ready = 1'b1;
        drain(12);

        // Address wrap and redirect to top of PC space
        start_run(1'b1);
        push_run(32'h0, 9);
        sb_q.push_back(32'hFFFF_FFFC);
        sb_q.push_back(32'h0000_0000);
        for (int i = 0; i < 14; i++) begin
            bus.redirect_valid = (i == 11);
            bus.redirect_pc = 32'hFFFF_FFFC;
            @(negedge clk);
            if (i == 8) chk("wrap_addr", 32'(bus.imem_address), 32'h0);
            if (i == 10) chk("wrap_pc", bus.out_pc, 32'h20);
            if (i == 11) chk("rd3_addr", 32'(bus.imem_address), 32'h1C);
            if (i == 12) chk("rd3_gap", 32'(bus.out_valid), 32'd0);
            step();
        end
        bus.redirect_valid = 1'b0;
        drain(10);

        // Asynchronous reset with three entries queued
        start_run(1'b0);
        repeat (4) step();
        @(negedge clk);
        chk("ar_count", 32'(dut.u_fifo.count_o), 32'd3);
        chk("ar_valid_pre", 32'(bus.out_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.out_valid), 32'd0);
        chk("ar_pc", bus.out_pc, 32'h0);
        chk("ar_instr", bus.out_instruction, NOP_INSTRUCTION);
        chk("ar_addr", 32'(bus.imem_address), 32'h0);
        step();
        push_run(32'h0, 3);
        bus.out_ready = 1'b1;
        reset_n = 1'b1;
        drain(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
